// File: rtl/scan_watch_reader.sv
// Debugger-side master for a CPU watch scan chain: one capture, DATAWIDTH shifts, parallel word out.
// Define SCAN_SYNC_EN to put a 2-flop synchronizer on iScanOut (requires CLKDIV >= 3).
module scan_watch_reader #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned CLKDIV    = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 iStart,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [DATAWIDTH-1:0] oData,
    output logic                 oScanClk,
    output logic                 oScanIn,
    output logic [1:0]           oScanCtrl,
    input  logic                 iScanOut
);
    localparam int unsigned Period = 2 * CLKDIV;
    localparam int unsigned PhW    = (Period > 1) ? $clog2(Period) : 1;
    localparam int unsigned BitW   = $clog2(DATAWIDTH + 1);

    localparam logic [PhW-1:0]  PhLast   = PhW'(Period - 1);
    localparam logic [PhW-1:0]  PhSample = PhW'(CLKDIV - 1);
    localparam logic [PhW-1:0]  PhRise   = PhW'(CLKDIV);
    localparam logic [BitW-1:0] BitsAll  = BitW'(DATAWIDTH);

    localparam logic [1:0] CtrlIdle    = 2'b00;
    localparam logic [1:0] CtrlCapture = 2'b01;
    localparam logic [1:0] CtrlShift   = 2'b10;

    if (DATAWIDTH < 2) begin : g_chk_width
        $error("scan_watch_reader: DATAWIDTH must be at least 2");
    end
    if (CLKDIV < 1) begin : g_chk_div
        $error("scan_watch_reader: CLKDIV must be at least 1");
    end

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StShift,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [PhW-1:0]         phase_q, phase_d;
    logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATAWIDTH-1:0]   shreg_q, shreg_d;
    logic [DATAWIDTH-1:0]   data_q, data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   scan_clk_q, scan_clk_d;
    logic [1:0]             ctrl_q, ctrl_d;
    logic                   scan_bit;
    logic                   shifting_d;

`ifdef SCAN_SYNC_EN
    if (CLKDIV < 3) begin : g_chk_sync
        $error("scan_watch_reader: SCAN_SYNC_EN requires CLKDIV >= 3");
    end

    logic [1:0] sync_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], iScanOut};
        end
    end

    assign scan_bit = sync_q[1];
`else
    assign scan_bit = iScanOut;
`endif

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;

        unique case (state_q)
            StIdle: begin
                if (iStart) begin
                    state_d = StCapture;
                    phase_d = '0;
                end
            end
            StCapture: begin
                if (phase_q == PhLast) begin
                    state_d   = StShift;
                    phase_d   = '0;
                    bit_cnt_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StShift: begin
                // bit_cnt_q == DATAWIDTH is a one-cycle tail with TCK low and controls at 00
                if (bit_cnt_q == BitsAll) begin
                    state_d = StDone;
                    data_d  = shreg_q;
                end else begin
                    if (phase_q == PhSample) begin
                        shreg_d = {scan_bit, shreg_q[DATAWIDTH-1:1]};
                    end
                    if (phase_q == PhLast) begin
                        phase_d   = '0;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d   = StIdle;
                bit_cnt_d = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so TCK and controls are glitch-free flops.
    always_comb begin
        shifting_d = (state_d == StShift) && (bit_cnt_d != BitsAll);
        busy_d     = (state_d != StIdle);
        done_d     = (state_d == StDone);
        scan_clk_d = ((state_d == StCapture) || shifting_d) && (phase_d >= PhRise);
        ctrl_d     = CtrlIdle;
        if (state_d == StCapture) begin
            ctrl_d = CtrlCapture;
        end else if (shifting_d) begin
            ctrl_d = CtrlShift;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            scan_clk_q <= 1'b0;
            ctrl_q     <= CtrlIdle;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            scan_clk_q <= scan_clk_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign oBusy     = busy_q;
    assign oDone     = done_q;
    assign oData     = data_q;
    assign oScanClk  = scan_clk_q;
    assign oScanIn   = 1'b0;
    assign oScanCtrl = ctrl_q;

endmodule

// File: tb/tb_scan_watch_reader.sv
// Scoreboard bench for scan_watch_reader: behavioural scan chain, read-level reference model,
// and a monitor that checks every oDone against queued expectations.
`timescale 1ns/1ps
module tb_scan_watch_reader;
    localparam int unsigned W = 8;
`ifdef SCAN_SYNC_EN
    localparam int unsigned C = 3;
`else
    localparam int unsigned C = 2;
`endif
    localparam int L = (W + 1) * 2 * C + 1;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         iStart;
    logic         oBusy;
    logic         oDone;
    logic [W-1:0] oData;
    logic         oScanClk;
    logic         oScanIn;
    logic [1:0]   oScanCtrl;
    logic         iScanOut;

    always #5 Clk = ~Clk;

    scan_watch_reader #(
        .DATAWIDTH (W),
        .CLKDIV    (C)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .iStart    (iStart),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oData     (oData),
        .oScanClk  (oScanClk),
        .oScanIn   (oScanIn),
        .oScanCtrl (oScanCtrl),
        .iScanOut  (iScanOut)
    );

    // Behavioural watch chain
    logic [W-1:0] chain_word;
    logic [W-1:0] chain_sr;
    always @(posedge oScanClk) begin
        if (oScanCtrl[0]) chain_sr <= chain_word;
        else if (oScanCtrl[1]) chain_sr <= {1'b0, chain_sr[W-1:1]};
    end
    assign iScanOut = chain_sr[0];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: a read accepted at edge e completes with oDone after edge e+L and
    // returns the chain word present at acceptance; the reader is free again from edge e+L+2.
    typedef struct {
        int           done_edge;
        logic [W-1:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] rise_q[$];
    int         cyc = 0;
    int         free_edge = 0;
    int         acc_edge = 0;
    int         rise_total = 0;
    int         done_count = 0;

    always @(posedge Clk) begin
        int e;
        e = cyc + 1;
        cyc <= e;
        if (Reset) begin
            exp_q.delete();
            free_edge <= e + 1;
        end else if (iStart && e >= free_edge) begin
            exp_q.push_back('{done_edge: e + L, data: chain_word});
            free_edge <= e + L + 2;
            acc_edge  <= e;
            rise_q.delete();
        end
    end

    always @(posedge oScanClk) begin
        rise_q.push_back(oScanCtrl);
        rise_total <= rise_total + 1;
    end

    // Monitor
    logic [W-1:0] hold_val = '0;
    logic         busy_chk = 1'b0;
    always @(negedge Clk) begin
        exp_t x;
        int   bad;
        if (busy_chk) check("busy_fall", 32'(oBusy), 32'd0);
        busy_chk <= 1'b0;
        if (oDone) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(oDone), 32'd0);
                hold_val <= oData;
            end else begin
                x = exp_q.pop_front();
                check("done_latency", 32'(cyc), 32'(x.done_edge));
                check("done_data", 32'(oData), 32'(x.data));
                check("busy_in_done", 32'(oBusy), 32'd1);
                check("rise_count", 32'(rise_q.size()), 32'(W + 1));
                bad = 0;
                foreach (rise_q[i]) begin
                    if (rise_q[i] !== ((i == 0) ? 2'b01 : 2'b10)) bad++;
                end
                check("rise_ctrl", 32'(bad), 32'd0);
                hold_val <= x.data;
                busy_chk <= 1'b1;
            end
            done_count <= done_count + 1;
        end else begin
            check("data_hold", 32'(oData), Reset ? 32'd0 : 32'(hold_val));
            if (Reset) hold_val <= '0;
        end
    end

    task automatic pulse_start();
        @(negedge Clk);
        iStart = 1'b1;
        @(negedge Clk);
        iStart = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge Clk);
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge Clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 32'(oBusy), 32'd0);
        check({tag, "_done"}, 32'(oDone), 32'd0);
        check({tag, "_data"}, 32'(oData), 32'd0);
        check({tag, "_sclk"}, 32'(oScanClk), 32'd0);
        check({tag, "_sin"}, 32'(oScanIn), 32'd0);
        check({tag, "_ctrl"}, 32'(oScanCtrl), 32'd0);
    endtask

    task automatic do_read(input logic [W-1:0] word);
        chain_word = word;
        pulse_start();
        wait_drain(4 * L);
    endtask

    initial begin
        int target;
        int n;
        Reset      = 1'b1;
        iStart     = 1'b0;
        chain_word = '0;

        // Reset with no start: everything idle, TCK never rises
        repeat (3) @(negedge Clk);
        check_outputs_zero("rst");
        Reset = 1'b0;
        repeat (40) @(negedge Clk);
        check("idle_sclk", 32'(oScanClk), 32'd0);
        check("idle_rises", 32'(rise_total), 32'd0);
        check("idle_busy", 32'(oBusy), 32'd0);

        // Basic read and the 0x81 MSB/LSB pattern
        do_read(8'hA5);
        do_read(8'h81);
        do_read(8'hA5);

        // Back-to-back with iStart held high; chain changes after the first capture
        target = done_count + 1;
        @(negedge Clk);
        iStart = 1'b1;
        repeat (10) @(negedge Clk);
        chain_word = 8'h3C;
        n = 0;
        while (done_count < target && n < 4 * L) begin
            @(negedge Clk);
            n++;
        end
        check("b2b_first_done", 32'(done_count), 32'(target));
        repeat (3) @(negedge Clk);
        iStart = 1'b0;
        repeat (10) @(negedge Clk);
        check("b2b_hold_old", 32'(oData), 32'h00A5);
        check("b2b_second_busy", 32'(oBusy), 32'd1);
        wait_drain(4 * L);
        check("b2b_total_done", 32'(done_count), 32'(target + 1));

        // Extra iStart pulses mid-SHIFT are ignored
        target = done_count + 1;
        chain_word = 8'h5E;
        pulse_start();
        repeat (2 * C + 6) @(negedge Clk);
        for (int k = 0; k < 3; k++) begin
            iStart = 1'b1;
            @(negedge Clk);
            iStart = 1'b0;
            repeat (2) @(negedge Clk);
        end
        wait_drain(4 * L);
        repeat (2 * L) @(negedge Clk);
        check("ignore_single_done", 32'(done_count), 32'(target));

        // Reset during the 4th shift period, then a clean read
        chain_word = 8'hA5;
        pulse_start();
        target = acc_edge + 2 * C + 3 * 2 * C + 1;
        n = 0;
        while (cyc < target && n < 4 * L) begin
            @(negedge Clk);
            n++;
        end
        #2 Reset = 1'b1;
        #1 check_outputs_zero("midrst");
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        check("midrst_queue", 32'(exp_q.size()), 32'd0);
        do_read(8'hA5);

        // Randomized reads with random gaps and ignored pulses
        for (int r = 0; r < 8; r++) begin
            chain_word = W'($urandom_range(0, 255));
            repeat ($urandom_range(0, 5)) @(negedge Clk);
            pulse_start();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(3, 20)) @(negedge Clk);
                iStart = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge Clk);
                iStart = 1'b0;
            end
            wait_drain(4 * L);
        end

        repeat (5) @(negedge Clk);
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
